// File: rtl/instr_sequencer.sv
// Mini SRC control unit: fetches, decodes the IR opcode and steps through the
// control sequence of each instruction class, holding memory steps for MEM_WAIT cycles.
module instr_sequencer #(
  parameter int MEM_WAIT = 1,
  parameter int OPC_W    = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        con,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        ram_read,
  output logic        ram_write,
  output logic        MDR_read,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        e_Rin,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic        e_CON_FF,
  output logic        done,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_T3, S_T4, S_T5,
    S_T6, S_T7, S_T8, S_DONE, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_LDI, C_LD, C_ST, C_ALU, C_BR, C_HALT, C_ILL
  } cls_t;

  localparam logic [4:0] BUS_ZLO   = 5'b10011;
  localparam logic [4:0] BUS_PC    = 5'b10100;
  localparam logic [4:0] BUS_MDR   = 5'b10101;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t           state_reg;
  cls_t             cls_reg;
  cls_t             cls_now;
  logic [3:0]       wait_reg;
  logic             illegal_reg;
  logic [OPC_W-1:0] opcode;
  logic             unused_ir;

  assign opcode    = ir[31 -: OPC_W];
  assign unused_ir = ^ir;

  always_comb begin
    cls_now = C_ILL;
    if (opcode == OPC_W'(0))                              cls_now = C_LD;
    else if (opcode == OPC_W'(1))                         cls_now = C_LDI;
    else if (opcode == OPC_W'(2))                         cls_now = C_ST;
    else if (opcode >= OPC_W'(3) && opcode <= OPC_W'(12)) cls_now = C_ALU;
    else if (opcode == OPC_W'(18))                        cls_now = C_BR;
    else if (opcode == OPC_W'(26))                        cls_now = C_NOP;
    else if (opcode == OPC_W'(27))                        cls_now = C_HALT;
  end

  // The instruction class is latched at T3 so later steps do not depend on ir decode timing.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg   <= S_IDLE;
      cls_reg     <= C_NOP;
      wait_reg    <= 4'd0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (run) state_reg <= S_F0;
        S_F0: begin
          state_reg <= S_F1;
          wait_reg  <= WAIT_INIT;
        end
        S_F1: begin
          if (wait_reg == 4'd0) state_reg <= S_F2;
          else                  wait_reg  <= wait_reg - 4'd1;
        end
        S_F2: state_reg <= S_F3;
        S_F3: state_reg <= S_T3;
        S_T3: begin
          cls_reg     <= cls_now;
          illegal_reg <= (cls_now == C_ILL);
          case (cls_now)
            C_NOP, C_ILL: state_reg <= S_DONE;
            C_HALT:       state_reg <= S_HALT;
            default:      state_reg <= S_T4;
          endcase
        end
        S_T4: state_reg <= S_T5;
        S_T5: begin
          if (cls_reg == C_LDI || cls_reg == C_ALU) begin
            state_reg <= S_DONE;
          end else begin
            state_reg <= S_T6;
            wait_reg  <= WAIT_INIT;
          end
        end
        S_T6: begin
          if (cls_reg == C_LD) begin
            if (wait_reg == 4'd0) state_reg <= S_T7;
            else                  wait_reg  <= wait_reg - 4'd1;
          end else if (cls_reg == C_ST) begin
            state_reg <= S_T7;
            wait_reg  <= WAIT_INIT;
          end else begin
            state_reg <= S_DONE;
          end
        end
        S_T7: begin
          if (cls_reg == C_LD)       state_reg <= S_T8;
          else if (wait_reg == 4'd0) state_reg <= S_DONE;
          else                       wait_reg  <= wait_reg - 4'd1;
        end
        S_T8: state_reg <= S_DONE;
        S_DONE: begin
          illegal_reg <= 1'b0;
          state_reg   <= run ? S_F0 : S_IDLE;
        end
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    incPC = 1'b0; e_PC = 1'b0; e_IR = 1'b0; e_Y = 1'b0; e_Z = 1'b0;
    e_MDR = 1'b0; e_MAR = 1'b0; ram_read = 1'b0; ram_write = 1'b0; MDR_read = 1'b0;
    ALU_op = 4'd0; BusDataSelect = 5'd0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; e_Rin = 1'b0; e_Rout = 1'b0;
    BAout = 1'b0; imm_sel = 1'b0; e_CON_FF = 1'b0;
    done = 1'b0; halted = 1'b0; illegal = 1'b0;
    case (state_reg)
      S_F0: begin BusDataSelect = BUS_PC; e_MAR = 1'b1; incPC = 1'b1; end
      S_F1: ram_read = 1'b1;
      S_F2: begin MDR_read = 1'b1; e_MDR = 1'b1; end
      S_F3: begin BusDataSelect = BUS_MDR; e_IR = 1'b1; end
      S_T3: begin
        case (cls_now)
          C_LDI, C_LD, C_ST: begin Grb = 1'b1; BAout = 1'b1; e_Rout = 1'b1; e_Y = 1'b1; end
          C_ALU:             begin Grb = 1'b1; e_Rout = 1'b1; e_Y = 1'b1; end
          C_BR:              begin Gra = 1'b1; e_Rout = 1'b1; e_CON_FF = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls_reg)
          C_ALU:   begin Grc = 1'b1; e_Rout = 1'b1; ALU_op = ir[30:27]; e_Z = 1'b1; end
          C_BR:    begin BusDataSelect = BUS_PC; e_Y = 1'b1; end
          default: begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
        endcase
      end
      S_T5: begin
        case (cls_reg)
          C_LD, C_ST: begin BusDataSelect = BUS_ZLO; e_MAR = 1'b1; end
          C_BR:       begin imm_sel = 1'b1; ALU_op = ALU_ADD; e_Z = 1'b1; end
          default:    begin BusDataSelect = BUS_ZLO; Gra = 1'b1; e_Rin = 1'b1; end
        endcase
      end
      S_T6: begin
        case (cls_reg)
          C_LD:    ram_read = 1'b1;
          C_ST:    begin Gra = 1'b1; e_Rout = 1'b1; e_MDR = 1'b1; end
          default: begin BusDataSelect = BUS_ZLO; e_PC = con; end
        endcase
      end
      S_T7: begin
        if (cls_reg == C_LD) begin MDR_read = 1'b1; e_MDR = 1'b1; end
        else                 ram_write = 1'b1;
      end
      S_T8:   begin BusDataSelect = BUS_MDR; Gra = 1'b1; e_Rin = 1'b1; end
      S_DONE: begin done = 1'b1; illegal = illegal_reg; end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle control vectors for each instruction class.
module tb_instr_sequencer;

  typedef logic [29:0] cv_t;

  localparam cv_t O_INC  = cv_t'(1) << 29;
  localparam cv_t O_EPC  = cv_t'(1) << 28;
  localparam cv_t O_EIR  = cv_t'(1) << 27;
  localparam cv_t O_EY   = cv_t'(1) << 26;
  localparam cv_t O_EZ   = cv_t'(1) << 25;
  localparam cv_t O_EMDR = cv_t'(1) << 24;
  localparam cv_t O_EMAR = cv_t'(1) << 23;
  localparam cv_t O_RD   = cv_t'(1) << 22;
  localparam cv_t O_WR   = cv_t'(1) << 21;
  localparam cv_t O_MDRR = cv_t'(1) << 20;
  localparam cv_t O_GRA  = cv_t'(1) << 10;
  localparam cv_t O_GRB  = cv_t'(1) << 9;
  localparam cv_t O_GRC  = cv_t'(1) << 8;
  localparam cv_t O_RIN  = cv_t'(1) << 7;
  localparam cv_t O_ROUT = cv_t'(1) << 6;
  localparam cv_t O_BA   = cv_t'(1) << 5;
  localparam cv_t O_IMM  = cv_t'(1) << 4;
  localparam cv_t O_ECON = cv_t'(1) << 3;
  localparam cv_t O_DONE = cv_t'(1) << 2;
  localparam cv_t O_HALT = cv_t'(1) << 1;
  localparam cv_t O_ILL  = cv_t'(1);
  localparam cv_t B_ZLO  = cv_t'(5'b10011) << 11;
  localparam cv_t B_PC   = cv_t'(5'b10100) << 11;
  localparam cv_t B_MDR  = cv_t'(5'b10101) << 11;
  localparam cv_t A_ADD  = cv_t'(4'b0011) << 16;
  localparam cv_t Z      = cv_t'(0);
  localparam cv_t F_0    = B_PC | O_EMAR | O_INC;
  localparam cv_t F_2    = O_MDRR | O_EMDR;
  localparam cv_t F_3    = B_MDR | O_EIR;
  localparam cv_t T3_IMM = O_GRB | O_BA | O_ROUT | O_EY;
  localparam cv_t T4_IMM = O_IMM | A_ADD | O_EZ;
  localparam logic [31:0] IR_JUNK = 32'h6800_0000;

  logic clock, clear;
  logic run, con, run0, con0;
  logic [31:0] ir, ir0;
  int passed = 0;
  int total  = 0;

  logic incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, ram_read, ram_write, MDR_read;
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;
  logic Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, e_CON_FF, done, halted, illegal;
  cv_t ctl;

  logic incPC0, e_PC0, e_IR0, e_Y0, e_Z0, e_MDR0, e_MAR0, ram_read0, ram_write0, MDR_read0;
  logic [3:0] ALU_op0;
  logic [4:0] BusDataSelect0;
  logic Gra0, Grb0, Grc0, e_Rin0, e_Rout0, BAout0, imm_sel0, e_CON_FF0, done0, halted0, illegal0;
  cv_t ctl0;

  assign ctl = {incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, ram_read, ram_write, MDR_read,
                ALU_op, BusDataSelect, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, e_CON_FF,
                done, halted, illegal};
  assign ctl0 = {incPC0, e_PC0, e_IR0, e_Y0, e_Z0, e_MDR0, e_MAR0, ram_read0, ram_write0, MDR_read0,
                 ALU_op0, BusDataSelect0, Gra0, Grb0, Grc0, e_Rin0, e_Rout0, BAout0, imm_sel0,
                 e_CON_FF0, done0, halted0, illegal0};

  instr_sequencer #(.MEM_WAIT(1), .OPC_W(5)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .con(con),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_MDR(e_MDR), .e_MAR(e_MAR),
    .ram_read(ram_read), .ram_write(ram_write), .MDR_read(MDR_read),
    .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout),
    .imm_sel(imm_sel), .e_CON_FF(e_CON_FF), .done(done), .halted(halted), .illegal(illegal)
  );

  instr_sequencer #(.MEM_WAIT(0), .OPC_W(5)) dut0 (
    .clock(clock), .clear(clear), .run(run0), .ir(ir0), .con(con0),
    .incPC(incPC0), .e_PC(e_PC0), .e_IR(e_IR0), .e_Y(e_Y0), .e_Z(e_Z0), .e_MDR(e_MDR0),
    .e_MAR(e_MAR0), .ram_read(ram_read0), .ram_write(ram_write0), .MDR_read(MDR_read0),
    .ALU_op(ALU_op0), .BusDataSelect(BusDataSelect0),
    .Gra(Gra0), .Grb(Grb0), .Grc(Grc0), .e_Rin(e_Rin0), .e_Rout(e_Rout0), .BAout(BAout0),
    .imm_sel(imm_sel0), .e_CON_FF(e_CON_FF0), .done(done0), .halted(halted0), .illegal(illegal0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    #2;
    total++;
    if (ctl !== Z) $display("FAIL reset_outputs: ctl=%h expected %h", ctl, Z); else passed++;
    total++;
    if (ctl0 !== Z) $display("FAIL reset_outputs_mw0: ctl=%h expected %h", ctl0, Z); else passed++;
    run = 1'b1;
    @(negedge clock);
    total++;
    if (ctl !== Z) $display("FAIL reset_holds: ctl=%h expected %h", ctl, Z); else passed++;
    run = 1'b0;
    clear = 1'b0;
    @(negedge clock);
    total++;
    if (ctl !== Z) $display("FAIL reset_idle: ctl=%h expected %h", ctl, Z); else passed++;
    $display("reset: outputs checked during and after clear");
  endtask

  task automatic test_ldi();
    cv_t ex[$];
    ex = '{F_0, O_RD, O_RD, F_2, F_3, T3_IMM, T4_IMM, B_ZLO | O_GRA | O_RIN, O_DONE, Z};
    ir = IR_JUNK;
    @(negedge clock);
    run = 1'b1;
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clock);
      run = 1'b0;
      total++;
      if (ctl !== ex[i]) $display("FAIL ldi step %0d: ctl=%h expected %h", i, ctl, ex[i]);
      else passed++;
      if (i == 4) ir = 32'h0900_0078;
    end
    $display("ldi R2,0x78: %0d steps, done expected at cycle 9", ex.size());
  endtask

  task automatic test_ld();
    cv_t ex[$];
    ex = '{F_0, O_RD, O_RD, F_2, F_3, T3_IMM, T4_IMM, B_ZLO | O_EMAR, O_RD, O_RD,
           O_MDRR | O_EMDR, B_MDR | O_GRA | O_RIN, O_DONE, Z};
    ir = IR_JUNK;
    @(negedge clock);
    run = 1'b1;
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clock);
      run = 1'b0;
      total++;
      if (ctl !== ex[i]) $display("FAIL ld step %0d: ctl=%h expected %h", i, ctl, ex[i]);
      else passed++;
      if (i == 4) ir = 32'h0310_0063;
    end
    $display("ld R6,0x63(R2): %0d steps, ram_read held 2 cycles in T6", ex.size());
  endtask

  task automatic test_alu();
    cv_t ex[$];
    logic [4:0] ops [2];
    logic [4:0] op;
    ops[0] = 5'b00100;
    ops[1] = 5'b01100;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      ex = '{F_0, O_RD, O_RD, F_2, F_3, O_GRB | O_ROUT | O_EY,
             O_GRC | O_ROUT | (cv_t'(op[3:0]) << 16) | O_EZ, B_ZLO | O_GRA | O_RIN, O_DONE, Z};
      ir = IR_JUNK;
      @(negedge clock);
      run = 1'b1;
      for (int i = 0; i < ex.size(); i++) begin
        @(negedge clock);
        run = 1'b0;
        total++;
        if (ctl !== ex[i]) $display("FAIL alu op=%b step %0d: ctl=%h expected %h", op, i, ctl, ex[i]);
        else passed++;
        if (i == 4) ir = {op, 27'h01A_2000};
      end
      $display("alu opcode %b: ALU_op %b in T4", op, op[3:0]);
    end
  endtask

  task automatic test_branch();
    cv_t ex[$];
    for (int c = 1; c >= 0; c--) begin
      con = c[0];
      ex = '{F_0, O_RD, O_RD, F_2, F_3, O_GRA | O_ROUT | O_ECON, B_PC | O_EY, T4_IMM,
             B_ZLO | (c[0] ? O_EPC : Z), O_DONE, Z};
      ir = IR_JUNK;
      @(negedge clock);
      run = 1'b1;
      for (int i = 0; i < ex.size(); i++) begin
        @(negedge clock);
        run = 1'b0;
        total++;
        if (ctl !== ex[i]) $display("FAIL br con=%0d step %0d: ctl=%h expected %h", c, i, ctl, ex[i]);
        else passed++;
        if (i == 4) ir = 32'h9200_0010;
      end
      $display("br offset 0x10 con=%0d: e_PC=%0d in T6", c, c);
    end
    con = 1'b0;
  endtask

  task automatic test_illegal();
    cv_t ex[$];
    logic [4:0] ops [2];
    ops[0] = 5'b11111;
    ops[1] = 5'b01101;
    ex = '{F_0, O_RD, O_RD, F_2, F_3, Z, O_DONE | O_ILL, Z};
    for (int k = 0; k < 2; k++) begin
      ir = 32'h0000_0000;
      @(negedge clock);
      run = 1'b1;
      for (int i = 0; i < ex.size(); i++) begin
        @(negedge clock);
        run = 1'b0;
        total++;
        if (ctl !== ex[i]) $display("FAIL illegal op=%b step %0d: ctl=%h expected %h", ops[k], i, ctl, ex[i]);
        else passed++;
        if (i == 4) ir = {ops[k], 27'd0};
      end
      $display("undefined opcode %b: illegal pulse in DONE", ops[k]);
    end
  endtask

  task automatic test_back_to_back();
    cv_t ex[$];
    ex = '{F_0, O_RD, O_RD, F_2, F_3, Z, O_DONE,
           F_0, O_RD, O_RD, F_2, F_3, T3_IMM, T4_IMM, B_ZLO | O_GRA | O_RIN, O_DONE, Z};
    ir = IR_JUNK;
    @(negedge clock);
    run = 1'b1;
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clock);
      if (i == 12) run = 1'b0;
      total++;
      if (ctl !== ex[i]) $display("FAIL back_to_back step %0d: ctl=%h expected %h", i, ctl, ex[i]);
      else passed++;
      if (i == 4) ir = 32'hD000_0000;
      if (i == 11) ir = 32'h0900_0078;
    end
    $display("back-to-back nop then ldi: F0 directly after DONE");
  endtask

  task automatic test_store_mw0();
    cv_t ex[$];
    ex = '{F_0, O_RD, F_2, F_3, T3_IMM, T4_IMM, B_ZLO | O_EMAR, O_GRA | O_ROUT | O_EMDR,
           O_WR, O_DONE, Z};
    ir0 = IR_JUNK;
    @(negedge clock);
    run0 = 1'b1;
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clock);
      run0 = 1'b0;
      total++;
      if (ctl0 !== ex[i]) $display("FAIL st_mw0 step %0d: ctl=%h expected %h", i, ctl0, ex[i]);
      else passed++;
      if (i == 3) ir0 = 32'h1180_0010;
    end
    $display("st R3 with MEM_WAIT=0: single ram_write cycle");
  endtask

  task automatic test_clear_mid_ld();
    cv_t ex[$];
    ex = '{F_0, O_RD, O_RD, F_2, F_3, T3_IMM, T4_IMM, B_ZLO | O_EMAR, O_RD};
    ir = IR_JUNK;
    @(negedge clock);
    run = 1'b1;
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clock);
      run = 1'b0;
      total++;
      if (ctl !== ex[i]) $display("FAIL clear_mid step %0d: ctl=%h expected %h", i, ctl, ex[i]);
      else passed++;
      if (i == 4) ir = 32'h0310_0063;
    end
    clear = 1'b1;
    #1;
    total++;
    if (ctl !== Z) $display("FAIL clear_mid_async: ctl=%h expected %h", ctl, Z); else passed++;
    @(negedge clock);
    clear = 1'b0;
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    total++;
    if (ctl !== F_0) $display("FAIL clear_mid_refetch: ctl=%h expected %h", ctl, F_0); else passed++;
    @(negedge clock);
    total++;
    if (ctl !== O_RD) $display("FAIL clear_mid_f1: ctl=%h expected %h", ctl, O_RD); else passed++;
    clear = 1'b1;
    #1;
    clear = 1'b0;
    $display("clear during ld T6: outputs dropped, refetch from F0");
  endtask

  task automatic test_halt();
    cv_t ex[$];
    ex = '{F_0, O_RD, O_RD, F_2, F_3, Z, O_HALT, O_HALT, O_HALT, O_HALT, O_HALT};
    ir = IR_JUNK;
    @(negedge clock);
    run = 1'b1;
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clock);
      run = (i >= 5) ? i[0] : 1'b0;
      total++;
      if (ctl !== ex[i]) $display("FAIL halt step %0d: ctl=%h expected %h", i, ctl, ex[i]);
      else passed++;
      if (i == 4) ir = 32'hD800_0000;
    end
    clear = 1'b1;
    #1;
    total++;
    if (ctl !== Z) $display("FAIL halt_clear: ctl=%h expected %h", ctl, Z); else passed++;
    @(negedge clock);
    clear = 1'b0;
    run = 1'b0;
    @(negedge clock);
    total++;
    if (ctl !== Z) $display("FAIL halt_idle: ctl=%h expected %h", ctl, Z); else passed++;
    $display("halt: halted sticky with run toggling, cleared to IDLE");
  endtask

  initial begin
    clear = 1'b1;
    run   = 1'b0;
    con   = 1'b0;
    ir    = 32'd0;
    run0  = 1'b0;
    con0  = 1'b0;
    ir0   = 32'd0;
    test_reset();
    test_ldi();
    test_ld();
    test_alu();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_store_mw0();
    test_clear_mid_ld();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
